// File: rtl/alu_issue_ctrl.sv
// Purpose : decodes MIPS instruction words into ALU controls, sequences the ALU and returns results; owns HI/LO.
// Latency : ALU ops respond 2 cycles after accept, mult/div 1+MD_CYCLES, mfhi/mflo/illegal 1.
// Backpressure: one instruction in flight; instr_ready low until the response is consumed (res_ready).
//
// Ports: clk/rst_n (async active-low); instr_valid/instr_ready/instr = instruction channel;
//        alu_Y/alu_hi/alu_lo/alu_flags = ALU results in; alu_op/alu_sign/alu_cmp = ALU controls out;
//        res_valid/res_ready/res_data/res_flags/res_illegal = response channel; hi_reg/lo_reg = architectural
//        HI/LO; busy = not idle.
// Build option: define ALU_TRAP_OVF_EN to turn signed overflow on add/sub/addi into an illegal response.
module alu_issue_ctrl #(
    parameter int unsigned MD_CYCLES = 4,
    parameter logic [2:0]  CMP_SLT   = 3'b001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] alu_Y,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_sign,
    output logic [2:0]  alu_cmp,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_flags,
    output logic        res_illegal,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, MDWAIT, RESP} state_t;
    typedef enum logic [2:0] {K_ALU, K_MD, K_MFHI, K_MFLO, K_ILL} kind_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  md_cnt;
    logic [3:0]  d_op;
    logic [1:0]  d_sign;
    logic [2:0]  d_cmp;
    kind_t       d_kind;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        accept;
`ifdef ALU_TRAP_OVF_EN
    logic        d_trap;
    logic        trap_chk;
`endif

    // Register fields live in the ALU datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[25:6];

    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    assign instr_ready = (state_q == IDLE);
    assign res_valid   = (state_q == RESP);
    assign busy        = (state_q != IDLE);
    assign accept      = instr_valid && instr_ready;

    // Instruction decode: anything not matched stays illegal with zero controls.
    always_comb begin
        d_op   = 4'b0000;
        d_sign = 2'b00;
        d_cmp  = 3'b000;
        d_kind = K_ILL;
`ifdef ALU_TRAP_OVF_EN
        d_trap = 1'b0;
`endif
        if (opcode == 6'h00) begin
            d_kind = K_ALU;
            case (funct)
                6'h20: begin d_op = 4'b0001; d_sign = 2'b10;
`ifdef ALU_TRAP_OVF_EN
                             d_trap = 1'b1;
`endif
                       end
                6'h21: begin d_op = 4'b0001; d_sign = 2'b00; end
                6'h22: begin d_op = 4'b0001; d_sign = 2'b11;
`ifdef ALU_TRAP_OVF_EN
                             d_trap = 1'b1;
`endif
                       end
                6'h23: begin d_op = 4'b0001; d_sign = 2'b01; end
                6'h24: d_op = 4'b0100;
                6'h25: d_op = 4'b0101;
                6'h26: d_op = 4'b1100;
                6'h27: d_op = 4'b0110;
                6'h00: d_op = 4'b1000;
                6'h02: d_op = 4'b0111;
                6'h03: d_op = 4'b1001;
                6'h2A: begin d_op = 4'b1101; d_sign = 2'b10; d_cmp = CMP_SLT; end
                6'h2B: begin d_op = 4'b1101; d_sign = 2'b00; d_cmp = CMP_SLT; end
                6'h18: begin d_op = 4'b0010; d_sign = 2'b10; d_kind = K_MD; end
                6'h19: begin d_op = 4'b0010; d_sign = 2'b00; d_kind = K_MD; end
                6'h1A: begin d_op = 4'b0011; d_sign = 2'b10; d_kind = K_MD; end
                6'h1B: begin d_op = 4'b0011; d_sign = 2'b00; d_kind = K_MD; end
                6'h10: d_kind = K_MFHI;
                6'h12: d_kind = K_MFLO;
                default: d_kind = K_ILL;
            endcase
        end else begin
            d_kind = K_ALU;
            case (opcode)
                6'h08: begin d_op = 4'b0001; d_sign = 2'b10;
`ifdef ALU_TRAP_OVF_EN
                             d_trap = 1'b1;
`endif
                       end
                6'h09: begin d_op = 4'b0001; d_sign = 2'b00; end
                6'h0A: begin d_op = 4'b1101; d_sign = 2'b10; d_cmp = CMP_SLT; end
                6'h0C: d_op = 4'b0100;
                6'h0D: d_op = 4'b0101;
                6'h0E: d_op = 4'b1100;
                6'h0F: d_op = 4'b1010;
                default: d_kind = K_ILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (d_kind)
                        K_ALU:   state_d = EXEC;
                        K_MD:    state_d = MDWAIT;
                        default: state_d = RESP;
                    endcase
                end
            end
            EXEC:    state_d = RESP;
            MDWAIT:  if (md_cnt == 4'd0) state_d = RESP;
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op      <= 4'b0000;
            alu_sign    <= 2'b00;
            alu_cmp     <= 3'b000;
            res_data    <= 32'h0;
            res_flags   <= 4'h0;
            res_illegal <= 1'b0;
            hi_reg      <= 32'h0;
            lo_reg      <= 32'h0;
            md_cnt      <= 4'd0;
`ifdef ALU_TRAP_OVF_EN
            trap_chk    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_op   <= d_op;
                        alu_sign <= d_sign;
                        alu_cmp  <= d_cmp;
`ifdef ALU_TRAP_OVF_EN
                        trap_chk <= d_trap;
`endif
                        // HI/LO are read here, so a capture in an earlier MDWAIT is already visible.
                        case (d_kind)
                            K_MD:   md_cnt <= MD_LOAD;
                            K_MFHI: begin res_data <= hi_reg; res_flags <= 4'h0; res_illegal <= 1'b0; end
                            K_MFLO: begin res_data <= lo_reg; res_flags <= 4'h0; res_illegal <= 1'b0; end
                            K_ILL:  begin res_data <= 32'h0;  res_flags <= 4'h0; res_illegal <= 1'b1; end
                            default: ;
                        endcase
                    end
                end
                EXEC: begin
                    res_data    <= alu_Y;
                    res_flags   <= alu_flags;
                    res_illegal <= 1'b0;
`ifdef ALU_TRAP_OVF_EN
                    if (trap_chk && alu_flags[0]) begin
                        res_data    <= 32'h0;
                        res_illegal <= 1'b1;
                    end
`endif
                end
                MDWAIT: begin
                    if (md_cnt == 4'd0) begin
                        hi_reg    <= alu_hi;
                        lo_reg    <= alu_lo;
                        res_data  <= alu_lo;
                        res_flags <= 4'h0;
                    end else begin
                        md_cnt <= md_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        alu_op      <= 4'b0000;
                        alu_sign    <= 2'b00;
                        alu_cmp     <= 3'b000;
                        res_illegal <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int MD = 4;
`ifdef ALU_TRAP_OVF_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_Y, alu_hi, alu_lo;
    logic [3:0]  alu_flags;
    logic [3:0]  alu_op;
    logic [1:0]  alu_sign;
    logic [2:0]  alu_cmp;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_flags;
    logic        res_illegal;
    logic [31:0] hi_reg, lo_reg;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Architectural HI/LO as the bench believes them to be.
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    alu_issue_ctrl #(.MD_CYCLES(MD), .CMP_SLT(3'b001)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_Y(alu_Y), .alu_hi(alu_hi), .alu_lo(alu_lo), .alu_flags(alu_flags),
        .alu_op(alu_op), .alu_sign(alu_sign), .alu_cmp(alu_cmp),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .res_illegal(res_illegal),
        .hi_reg(hi_reg), .lo_reg(lo_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode. kind: 0 alu, 1 mult/div, 2 mfhi, 3 mflo, 4 illegal.
    task automatic ref_decode(input logic [31:0] w, output logic [3:0] op, output logic [1:0] sg,
                              output logic [2:0] cm, output int kind, output bit trap);
        logic [5:0] opc, fn;
        opc = w[31:26];
        fn  = w[5:0];
        op = 0; sg = 0; cm = 0; kind = 0; trap = 0;
        if (opc == 0) begin
            case (fn)
                6'h20: begin op = 1; sg = 2; trap = 1; end
                6'h21: begin op = 1; sg = 0; end
                6'h22: begin op = 1; sg = 3; trap = 1; end
                6'h23: begin op = 1; sg = 1; end
                6'h24: op = 4;
                6'h25: op = 5;
                6'h26: op = 12;
                6'h27: op = 6;
                6'h00: op = 8;
                6'h02: op = 7;
                6'h03: op = 9;
                6'h2A: begin op = 13; sg = 2; cm = 1; end
                6'h2B: begin op = 13; sg = 0; cm = 1; end
                6'h18: begin op = 2; sg = 2; kind = 1; end
                6'h19: begin op = 2; sg = 0; kind = 1; end
                6'h1A: begin op = 3; sg = 2; kind = 1; end
                6'h1B: begin op = 3; sg = 0; kind = 1; end
                6'h10: kind = 2;
                6'h12: kind = 3;
                default: kind = 4;
            endcase
        end else begin
            case (opc)
                6'h08: begin op = 1; sg = 2; trap = 1; end
                6'h09: begin op = 1; sg = 0; end
                6'h0A: begin op = 13; sg = 2; cm = 1; end
                6'h0C: op = 4;
                6'h0D: op = 5;
                6'h0E: op = 12;
                6'h0F: op = 10;
                default: kind = 4;
            endcase
        end
    endtask

    // One complete transaction; hold = cycles res_ready stays low while a response waits.
    task automatic run_instr(input logic [31:0] w, input logic [31:0] y, input logic [31:0] hi,
                             input logic [31:0] lo, input logic [3:0] fl, input int hold);
        logic [3:0]  eop;
        logic [1:0]  esg;
        logic [2:0]  ecm;
        int          kind;
        bit          trap;
        int          elat;
        int          c;
        logic [31:0] edata;
        logic [3:0]  efl;
        logic        eill;
        ref_decode(w, eop, esg, ecm, kind, trap);
        alu_Y = y; alu_hi = hi; alu_lo = lo; alu_flags = fl;
        case (kind)
            0: begin
                elat = 2; edata = y; efl = fl; eill = 1'b0;
                if (TRAP && trap && fl[0]) begin edata = 0; eill = 1'b1; end
            end
            1: begin elat = 1 + MD; edata = lo; efl = 0; eill = 1'b0; end
            2: begin elat = 1; edata = m_hi; efl = 0; eill = 1'b0; end
            3: begin elat = 1; edata = m_lo; efl = 0; eill = 1'b0; end
            default: begin elat = 1; edata = 0; efl = 0; eill = 1'b1; end
        endcase

        chk("rdy_idle", {31'b0, instr_ready}, 1);
        instr = w;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = $urandom;
        c = 1;
        while (!res_valid && c < 40) begin
            chk("op_hold", {28'b0, alu_op}, {28'b0, eop});
            chk("sign_hold", {30'b0, alu_sign}, {30'b0, esg});
            chk("cmp_hold", {29'b0, alu_cmp}, {29'b0, ecm});
            chk("rdy_busy", {31'b0, instr_ready}, 0);
            @(posedge clk); #1;
            c++;
        end
        chk("latency", 32'(c), 32'(elat));
        if (kind == 1) begin m_hi = hi; m_lo = lo; end
        chk("res_data", res_data, edata);
        chk("res_flags", {28'b0, res_flags}, {28'b0, efl});
        chk("res_illegal", {31'b0, res_illegal}, {31'b0, eill});
        chk("hi_reg", hi_reg, m_hi);
        chk("lo_reg", lo_reg, m_lo);
        chk("op_resp", {28'b0, alu_op}, {28'b0, eop});
        chk("busy_resp", {31'b0, busy}, 1);

        for (int i = 0; i < hold; i++) begin
            instr_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("valid_stall", {31'b0, res_valid}, 1);
            chk("data_stall", res_data, edata);
            chk("rdy_stall", {31'b0, instr_ready}, 0);
        end
        // Offer an instruction in the consuming cycle too; it must not be taken.
        res_ready = 1'b1;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        instr_valid = 1'b0;
        chk("valid_drop", {31'b0, res_valid}, 0);
        chk("rdy_back", {31'b0, instr_ready}, 1);
        chk("op_clear", {28'b0, alu_op}, 0);
        chk("ill_clear", {31'b0, res_illegal}, 0);
        chk("busy_idle", {31'b0, busy}, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_op"}, {28'b0, alu_op}, 0);
        chk({tag, "_sign"}, {30'b0, alu_sign}, 0);
        chk({tag, "_cmp"}, {29'b0, alu_cmp}, 0);
        chk({tag, "_rv"}, {31'b0, res_valid}, 0);
        chk({tag, "_rd"}, res_data, 0);
        chk({tag, "_rf"}, {28'b0, res_flags}, 0);
        chk({tag, "_ri"}, {31'b0, res_illegal}, 0);
        chk({tag, "_hi"}, hi_reg, 0);
        chk({tag, "_lo"}, lo_reg, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_rdy"}, {31'b0, instr_ready}, 1);
    endtask

    logic [5:0] r_functs [19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02,
                                  6'h03, 6'h2A, 6'h2B, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};
    logic [5:0] i_opcs [7] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

    initial begin
        logic [31:0] w;
        int          sel;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 0;
        res_ready = 1'b0;
        alu_Y = 0; alu_hi = 0; alu_lo = 0; alu_flags = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_instr(32'h00851021, 32'h0000_0009, 32'h0, 32'h0, 4'h0, 0);        // addu
        run_instr(32'h0000_0019, 32'h0, 32'h1, 32'hFFFF_FFFE, 4'h0, 0);       // multu
        run_instr(32'h0000_0010, 32'h0, 32'h0, 32'h0, 4'h0, 10);              // mfhi, long stall
        run_instr(32'hFC00_0000, 32'h1234, 32'h0, 32'h0, 4'h0, 1);            // opcode 3F
        run_instr(32'h00851020, 32'h8000_0000, 32'h0, 32'h0, 4'b0001, 0);     // add, overflow
        run_instr(32'h2085_0005, 32'h7FFF_FFFF, 32'h0, 32'h0, 4'b1001, 0);    // addi, overflow
        run_instr(32'h0000_001B, 32'h0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 4'hF, 2); // divu
        run_instr(32'h0000_0012, 32'h0, 32'h0, 32'h0, 4'h0, 0);               // mflo

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)
                w = {6'h00, 20'($urandom), r_functs[$urandom_range(0, 18)]};
            else if (sel < 8)
                w = {i_opcs[$urandom_range(0, 6)], 26'($urandom)};
            else
                w = $urandom;
            run_instr(w, $urandom, $urandom, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        // Make sure HI/LO hold something before the reset-abort case.
        run_instr(32'h0000_0018, 32'h0, 32'hA5A5_0001, 32'h5A5A_0002, 4'h0, 0);
        chk("hi_pre", hi_reg, 32'hA5A5_0001);

        // Reset in the middle of a mult: the operation disappears.
        alu_hi = 32'h1111_1111;
        alu_lo = 32'h2222_2222;
        instr = 32'h0000_0018;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("md_busy", {31'b0, busy}, 1);
        chk("md_op", {28'b0, alu_op}, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("mdrst");
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = 0;
        m_lo = 0;
        repeat (MD + 2) begin
            @(posedge clk); #1;
            chk("no_resp", {31'b0, res_valid}, 0);
        end
        run_instr(32'h0000_0010, 32'h0, 32'h0, 32'h0, 4'h0, 0);
        run_instr(32'h0000_0012, 32'h0, 32'h0, 32'h0, 4'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing front end for the datapath ALU. It accepts 32-bit MIPS instruction words through a valid/ready handshake and decodes opcode/funct into the ALU control inputs (operation, sign, compare select). It holds those controls steady for the required number of cycles, captures the ALU result, flags and HI/LO products, and returns the result through a valid/ready response channel. It owns the architectural HI/LO registers, so it also serves mfhi/mflo.

Parameters:
MD_CYCLES, 4, cycles the multiply/divide controls are held before HI/LO capture (legal range 1..15)
CMP_SLT, 3'b001, compare-select code driven for slt/sltu/slti

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word offered
instr_ready  out  1  block can accept an instruction
instr  in  32  instruction; [31:26] opcode, [5:0] funct
alu_Y  in  32  ALU result
alu_hi  in  32  ALU HI output
alu_lo  in  32  ALU LO output
alu_flags  in  4  ALU flags {C,Z,N,V}, bit0=V
alu_op  out  4  ALU operation code
alu_sign  out  2  ALU sign/add-sub select
alu_cmp  out  3  ALU compare select
res_valid  out  1  response available
res_ready  in  1  response consumed
res_data  out  32  response value
res_flags  out  4  flags captured with response
res_illegal  out  1  response is for an undecodable instruction
hi_reg  out  32  architectural HI
lo_reg  out  32  architectural LO
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE; alu_op=4'b0000, alu_sign=2'b00, alu_cmp=3'b000; res_valid=0, res_data=0, res_flags=0, res_illegal=0; hi_reg=lo_reg=0; md counter=0. instr_ready=1 after reset is released.
- States: IDLE, EXEC, MDWAIT, RESP.
- IDLE: instr_ready=1. On instr_valid&instr_ready, register the decoded controls and go to:
  - EXEC for ALU ops
  - MDWAIT (counter=MD_CYCLES-1) for mult/div
  - RESP directly for mfhi/mflo/illegal
- Decode, opcode 0 (funct -> op,sign): add 20h->0001,10; addu 21h->0001,00; sub 22h->0001,11; subu 23h->0001,01; and 24h->0100; or 25h->0101; xor 26h->1100; nor 27h->0110; sll 00h->1000; srl 02h->0111; sra 03h->1001; slt 2Ah->1101,10,cmp=CMP_SLT; sltu 2Bh->1101,00,cmp=CMP_SLT; mult 18h->0010,10; multu 19h->0010,00; div 1Ah->0011,10; divu 1Bh->0011,00; mfhi 10h; mflo 12h.
- Decode, other opcodes: addi 08h->0001,10; addiu 09h->0001,00; slti 0Ah->1101,10,CMP_SLT; andi 0Ch->0100; ori 0Dh->0101; xori 0Eh->1100; lui 0Fh->1010.
- Any other opcode/funct is illegal.
- Fields not listed above are 0.
- EXEC: lasts exactly one cycle. At its end, res_data<=alu_Y and res_flags<=alu_flags; go to RESP.
- MDWAIT: controls held constant. The counter decrements each cycle. At the edge where the counter is 0: hi_reg<=alu_hi, lo_reg<=alu_lo, res_data<=alu_lo, res_flags<=0; go to RESP. Total hold time is MD_CYCLES cycles.
- mfhi/mflo: res_data<=hi_reg or lo_reg at accept. alu_op stays 0000.
- Illegal instruction: res_illegal=1, res_data=0. HI/LO unchanged.
- RESP: res_valid=1; res_data, res_flags and res_illegal are stable. On res_ready: res_valid<=0, res_illegal<=0, alu controls<=0, go to IDLE.
- res_ready while res_valid=0 is ignored.
- No new instruction is accepted in the cycle a response is consumed; instr_ready rises the following cycle.
- instr_ready=0 in EXEC, MDWAIT and RESP. instr_valid there has no effect, and instr is not sampled.
- mfhi issued immediately after mult returns the new HI value, since the capture precedes the mfhi accept.
- Reset asserted mid-MDWAIT discards the operation: HI/LO=0 and no response is issued.

Optional Feature:
ALU_TRAP_OVF_EN: when defined, add, sub and addi whose captured alu_flags[0] (V)=1 produce a response with res_illegal=1 and res_data=0 (overflow trap).
When undefined, these return alu_Y with V visible only in res_flags, and res_illegal is driven only by decode failure.

Test Plan:
- Reset mid-MDWAIT of mult -> all outputs at reset values, instr_ready=1, hi_reg=lo_reg=0.
- addu (instr=32'h00851021) with alu_Y=32'h0000_0009 -> alu_op=0001 and alu_sign=00 during EXEC; res_valid two cycles after accept, res_data=9.
- multu (funct 19h), MD_CYCLES=4, alu_hi=32'h1, alu_lo=32'hFFFF_FFFE -> controls held 4 cycles; hi_reg=1, lo_reg=FFFFFFFE; then mfhi -> res_data=1.
- res_ready held low for 10 cycles in RESP -> res_valid and res_data stable; a second instr_valid is not accepted; accepted 1 cycle after res_ready.
- opcode 3Fh -> res_illegal=1, res_data=0, hi/lo unchanged.
- add with alu_flags=4'b0001 -> with ALU_TRAP_OVF_EN: res_illegal=1; without: res_data=alu_Y, res_flags=0001.
